// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned BYPASS_MAX = 1;

  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic logic is_odd(input logic [31:0] d);
    return d[0];
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Channel enables, divisor-update handshake and divided outputs of clk_div_multi.
interface clk_div_multi_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 24
);
  import clk_div_pkg::*;

  localparam int unsigned CH_W = ch_width(NCH);

  logic [NCH-1:0]   en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  modport master (
    output en, cfg_valid, cfg_ch, cfg_div,
    input  cfg_ready, clk_out, tick
  );

  modport slave (
    input  en, cfg_valid, cfg_ch, cfg_div,
    output cfg_ready, clk_out, tick
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadowed divisor, 50%-duty phase flops and tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned DEF_DIV = 12_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] cnt;
  logic             clk_p;
  logic             clk_n;
  logic             bypass;
  logic             wrap;
  logic             apply;

  // A shadowed divisor only lands on a period boundary, or at once when idle/bypassed.
  always_comb begin
    bypass = (div <= WIDTH'(BYPASS_MAX));
    wrap   = en && !bypass && (cnt == div - WIDTH'(1));
    apply  = pending && (wrap || !en || bypass);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= WIDTH'(DEF_DIV);
      shadow  <= WIDTH'(DEF_DIV);
      pending <= 1'b0;
      cnt     <= '0;
      clk_p   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (apply) begin
        div     <= shadow;
        pending <= 1'b0;
      end
      if (cfg_we) begin
        shadow  <= cfg_div;
        pending <= 1'b1;
      end
      if (!en || bypass) begin
        cnt   <= '0;
        clk_p <= 1'b0;
      end else begin
        cnt   <= wrap ? '0 : cnt + WIDTH'(1);
        clk_p <= (cnt >= (div >> 1));
      end
      tick <= bypass ? en : wrap;
    end
  end

  // Half-cycle delayed copy; ANDed with clk_p it trims odd divisors to 50% duty.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) clk_n <= 1'b0;
    else        clk_n <= clk_p & en;
  end

  always_comb begin
    if (bypass)                 clk_out = clk & en;
    else if (is_odd(32'(div)))  clk_out = clk_p & clk_n;
    else                        clk_out = clk_p;
  end

endmodule

// File: rtl/clk_div_multi.sv
// NCH-channel programmable clock divider: cfg decode, ready mux and channel array.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned DEF_DIV = 12_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_div_multi_if.slave bus
);

  localparam int unsigned CH_W = ch_width(NCH);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] we;
  logic [NCH-1:0] clk_out_w;
  logic [NCH-1:0] tick_w;
  logic           rdy;

  // Out-of-range channels stay ready so their transfers complete and are dropped.
  always_comb begin
    rdy = 1'b1;
    we  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.cfg_ch == CH_W'(i)) rdy = !pending[i];
    end
    for (int i = 0; i < NCH; i++) begin
      we[i] = bus.cfg_valid && rdy && (bus.cfg_ch == CH_W'(i));
    end
  end

  assign bus.cfg_ready = rdy;
  assign bus.clk_out   = clk_out_w;
  assign bus.tick      = tick_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en[i]),
      .cfg_we  (we[i]),
      .cfg_div (bus.cfg_div),
      .pending (pending[i]),
      .clk_out (clk_out_w[i]),
      .tick    (tick_w[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: divisor table plus handshake and reset sequences.
module tb_clk_div_multi;

  localparam int unsigned NCH     = 3;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEF_DIV = 4;
  localparam int unsigned CH_W    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  clk_div_multi_if #(.NCH(NCH), .WIDTH(WIDTH)) ifc ();

  clk_div_multi #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct {int ch; int div; int hi; int per; int tk;} vec_t;
  typedef struct {int ch; int hi; int per; int tk;} exp_t;

  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Posedges until tick[ch] is seen high; -1 when the budget runs out.
  task automatic wait_tick(input int ch, output int n);
    n = -1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (ifc.tick[ch]) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic measure_tick(input int ch, output int per, output int w);
    int n;
    per = -1;
    w   = -1;
    wait_tick(ch, n);
    if (n < 0) return;
    @(posedge clk); #1;
    w = int'(ifc.tick[ch]);
    wait_tick(ch, n);
    if (n >= 0) per = n + 1;
  endtask

  // High time and period of clk_out[ch] in half clk cycles, sampled after both edges.
  task automatic measure_clk(input int ch, output int hi, output int per);
    logic prev, cur;
    int   k;
    hi   = 0;
    per  = 0;
    prev = ifc.clk_out[ch];
    for (k = 0; k < 400; k++) begin
      @(clk); #1;
      cur = ifc.clk_out[ch];
      if (!prev && cur) break;
      prev = cur;
    end
    if (k == 400) return;
    hi = 1;
    for (k = 0; k < 400; k++) begin
      @(clk); #1;
      if (!ifc.clk_out[ch]) break;
      hi++;
    end
    per = hi + 1;
    for (k = 0; k < 400; k++) begin
      @(clk); #1;
      if (ifc.clk_out[ch]) break;
      per++;
    end
  endtask

  task automatic send_cfg(input int ch, input int dv);
    ifc.cfg_ch    = CH_W'(ch);
    ifc.cfg_div   = WIDTH'(dv);
    ifc.cfg_valid = 1'b1;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (ifc.cfg_ready) begin
        @(posedge clk); #1;
        ifc.cfg_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    ifc.cfg_valid = 1'b0;
    chk("cfg_ready_timeout", 0, 1);
  endtask

  initial begin
    int   n, hi, per, w, ones, k;
    exp_t e;

    vecs[0] = '{1, 5, 5, 10, 5};
    vecs[1] = '{2, 2, 2,  4, 2};
    vecs[2] = '{1, 7, 7, 14, 7};
    vecs[3] = '{2, 1, 1,  2, 0};
    vecs[4] = '{2, 0, 1,  2, 0};
    vecs[5] = '{1, 3, 3,  6, 3};

    ifc.en        = '0;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_ch    = '0;
    ifc.cfg_div   = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_clk_out", int'(ifc.clk_out), 0);
    chk("reset_tick", int'(ifc.tick), 0);
    chk("reset_cfg_ready", int'(ifc.cfg_ready), 1);

    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 ifc.en = 3'b111;
    wait_tick(0, n);
    chk("first_tick_ch0", n, 4);
    measure_tick(0, per, w);
    chk("tick_period_ch0", per, 4);
    chk("tick_width_ch0", w, 0);
    measure_clk(0, hi, per);
    chk("def_hi_ch0", hi, 4);
    chk("def_per_ch0", per, 8);

    // Divisor table: expectations queued at drive time, compared once the output settles.
    foreach (vecs[i]) begin
      send_cfg(vecs[i].ch, vecs[i].div);
      sb.push_back('{vecs[i].ch, vecs[i].hi, vecs[i].per, vecs[i].tk});
      repeat (20) @(posedge clk);
      #1;
      e = sb.pop_front();
      measure_clk(e.ch, hi, per);
      chk($sformatf("vec%0d_hi", i), hi, e.hi);
      chk($sformatf("vec%0d_per", i), per, e.per);
      if (e.tk > 0) begin
        measure_tick(e.ch, per, w);
        chk($sformatf("vec%0d_tick", i), per, e.tk);
        chk($sformatf("vec%0d_tick_w", i), w, 0);
      end else begin
        ones = 0;
        repeat (4) begin
          @(posedge clk); #1;
          ones += int'(ifc.tick[e.ch]);
        end
        chk($sformatf("vec%0d_bypass_tick", i), ones, 4);
      end
    end

    // Update ch0 from 4 to 6 one cycle into a period.
    wait_tick(0, n);
    ifc.cfg_ch    = 2'd0;
    ifc.cfg_div   = 8'd6;
    ifc.cfg_valid = 1'b1;
    @(posedge clk); #1;
    ifc.cfg_valid = 1'b0;
    chk("chg_ready_low", int'(ifc.cfg_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("chg_ready_hold", int'(ifc.cfg_ready), 0);
    chk("chg_no_early_tick", int'(ifc.tick[0]), 0);
    @(posedge clk); #1;
    chk("chg_old_period_tick", int'(ifc.tick[0]), 1);
    chk("chg_ready_back", int'(ifc.cfg_ready), 1);
    wait_tick(0, n);
    chk("chg_new_period1", n, 6);
    wait_tick(0, n);
    chk("chg_new_period2", n, 6);
    measure_clk(0, hi, per);
    chk("chg_hi", hi, 6);
    chk("chg_per", per, 12);

    // Bypassed ch2 with its enable dropped must go quiet.
    ifc.en[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ones = 0;
    repeat (8) begin
      @(clk); #1;
      ones += int'(ifc.clk_out[2]) + int'(ifc.tick[2]);
    end
    chk("bypass_off_quiet", ones, 0);

    // Disabled ch0: pending update applies next cycle, a held request stalls one cycle.
    ifc.en[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ifc.cfg_ch    = 2'd0;
    ifc.cfg_div   = 8'd8;
    ifc.cfg_valid = 1'b1;
    #1;
    chk("dis_ready_idle", int'(ifc.cfg_ready), 1);
    @(posedge clk); #1;
    chk("dis_ready_pending", int'(ifc.cfg_ready), 0);
    ifc.cfg_div = 8'd10;
    @(posedge clk); #1;
    chk("dis_applied_next", int'(ifc.cfg_ready), 1);
    @(posedge clk); #1;
    ifc.cfg_valid = 1'b0;
    chk("dis_second_accepted", int'(ifc.cfg_ready), 0);
    repeat (3) @(posedge clk);
    #1 ifc.en[0] = 1'b1;
    wait_tick(0, n);
    chk("dis_new_div", n, 10);

    // cfg_ch beyond NCH: accepted and dropped.
    ifc.cfg_ch    = 2'd3;
    ifc.cfg_div   = 8'd2;
    ifc.cfg_valid = 1'b1;
    #1;
    chk("oor_ready", int'(ifc.cfg_ready), 1);
    @(posedge clk); #1;
    ifc.cfg_valid = 1'b0;
    measure_tick(1, per, w);
    chk("oor_ch1_period", per, 3);
    measure_tick(0, per, w);
    chk("oor_ch0_period", per, 10);

    // Asynchronous reset while ch0 is in its high phase.
    for (k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (ifc.clk_out[0]) break;
    end
    chk("rst_pre_high", int'(ifc.clk_out[0]), 1);
    @(negedge clk); #1;
    chk("rst_pre_clk_n", int'(dut.g_ch[0].u_chan.clk_n), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_clk_out", int'(ifc.clk_out), 0);
    chk("rst_async_tick", int'(ifc.tick), 0);
    chk("rst_async_clk_n", int'(dut.g_ch[0].u_chan.clk_n), 0);
    chk("rst_async_ready", int'(ifc.cfg_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_tick(0, n);
    chk("rst_def_div_ch0", n, 4);
    chk("rst_def_div_ch1", int'(ifc.tick[1]), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
